// File: rtl/logical_tile_io_bank.sv
// Configurable I/O bank: serial config chain with shadow commit and per-pad direction/inversion.
// Pads stay in the safe input state until a full word has been committed.
module logical_tile_io_bank #(
  parameter int unsigned NUM_PADS = 4
) (
  input  logic                prog_clk,
  input  logic                pReset,
  input  logic                IO_ISOL_N,
  input  logic                ccff_en,
  input  logic                ccff_head,
  output logic                ccff_tail,
  input  logic [NUM_PADS-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_IN,
  output logic [NUM_PADS-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_OUT,
  output logic [NUM_PADS-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_DIR,
  input  logic [NUM_PADS-1:0] io_outpad,
  output logic [NUM_PADS-1:0] io_inpad,
  output logic                cfg_valid,
  output logic                cfg_busy,
  output logic                cfg_done
);

  localparam int unsigned CfgBits = 2;
  localparam int unsigned Total   = CfgBits * NUM_PADS;
  localparam int unsigned CntW    = (Total > 1) ? $clog2(Total) : 1;

  typedef enum logic [1:0] {
    StUnconfig,
    StShift,
    StCommit,
    StActive
  } state_e;

  state_e            state_q, state_d;
  logic [Total-1:0]  shift_q, shift_d;
  logic [Total-1:0]  shadow_q, shadow_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              safe;

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;

    // Shifting is independent of the FSM so a commit edge can also take the next word's first bit.
    if (ccff_en) begin
      shift_d = {shift_q[Total-2:0], ccff_head};
      cnt_d   = (cnt_q == CntW'(Total - 1)) ? '0 : cnt_q + CntW'(1);
    end

    unique case (state_q)
      StUnconfig: if (ccff_en) state_d = StShift;
      StShift:    if (ccff_en && (cnt_q == CntW'(Total - 1))) state_d = StCommit;
      StCommit: begin
        shadow_d = shift_q;
        valid_d  = 1'b1;
        state_d  = StActive;
      end
      StActive:   if (ccff_en) state_d = StShift;
      default:    state_d = StUnconfig;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q  <= StUnconfig;
      shift_q  <= '0;
      shadow_q <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
    end
  end

  assign ccff_tail = shift_q[Total-1];
  assign cfg_valid = valid_q;
  assign cfg_busy  = (state_q == StShift);
  assign cfg_done  = (state_q == StCommit);
  assign safe      = ~IO_ISOL_N | ~valid_q;

  // Even shadow bit is the output enable, odd bit the input inversion.
  always_comb begin
    gfpga_pad_EMBEDDED_IO_HD_SOC_DIR = '1;
    gfpga_pad_EMBEDDED_IO_HD_SOC_OUT = '0;
    io_inpad                         = '0;
    for (int k = 0; k < int'(NUM_PADS); k++) begin
      if (!safe) begin
        gfpga_pad_EMBEDDED_IO_HD_SOC_DIR[k] = ~shadow_q[2*k];
        gfpga_pad_EMBEDDED_IO_HD_SOC_OUT[k] = io_outpad[k] & shadow_q[2*k];
        io_inpad[k] = (gfpga_pad_EMBEDDED_IO_HD_SOC_IN[k] ^ shadow_q[2*k+1]) & ~shadow_q[2*k];
      end
    end
  end

endmodule
